// File: rtl/hdmi_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// hdmi_clk_rst_seq
//
// Reset sequencer for the HDMI TMDS path. Runs on the free-running 27 MHz
// board clock (the same net that feeds the PLL clkin), so it is alive before
// and during PLL lock. It pulses the PLL reset and waits for lock. Once lock
// has been stable for long enough, it releases the serializer domain first
// and the pixel/timing domain second. Both domains are re-asserted as soon
// as lock is lost.
//
// Ports:
//   clk          in   27 MHz free-running clock
//   reset        in   asynchronous, active-high block reset
//   lock         in   PLL lock, asynchronous to clk
//   pll_rst      out  PLL RESET, active high
//   ser_rst      out  serializer-domain reset request, active high
//   pix_rst      out  pixel-domain reset request, active high
//   ready        out  high only while the sequence is in RUN
//   retry_count  out  PLL reset pulses issued after the first, saturates at 15
//
// Build option:
//   HDMI_PLL_RETRY_EN  defined   -> WAIT_LOCK times out and the PLL reset is
//                                   pulsed again (retry_count counts these).
//                      undefined -> WAIT_LOCK waits forever, retry_count = 0,
//                                   and pll_rst stays low after the first pulse.
// ---------------------------------------------------------------------------
module hdmi_clk_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned SER_TO_PIX_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_rst,
  output logic       ser_rst,
  output logic       pix_rst,
  output logic       ready,
  output logic [3:0] retry_count
);

  // One-hot encoding: every output is a single flop bit (or the OR of two),
  // so the reset outputs cannot glitch on state changes.
  typedef enum logic [4:0] {
    S_PLL_RST   = 5'b00001,
    S_WAIT_LOCK = 5'b00010,
    S_STABLE    = 5'b00100,
    S_SER_REL   = 5'b01000,
    S_RUN       = 5'b10000
  } state_e;

  localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (PLL_RST_CYCLES > SER_TO_PIX_CYCLES) ?
                                    PLL_RST_CYCLES : SER_TO_PIX_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // "N cycles elapsed" is the last count value of a state, N-1.
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(SER_TO_PIX_CYCLES - 1);
`ifdef HDMI_PLL_RETRY_EN
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_meta_q;
  logic             lock_s_q;
`ifdef HDMI_PLL_RETRY_EN
  logic [3:0]       retry_q;
`endif

  // NOTE: sequential state is assigned with <= only, so every flop in this
  // block samples the pre-edge values of the others (the synchronizer relies
  // on this to form two distinct stages).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
`ifdef HDMI_PLL_RETRY_EN
      retry_q     <= 4'd0;
`endif
    end else begin
      // Raw lock is sampled here and nowhere else.
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;

      // Counter runs freely within a state and is cleared on every entry.
      cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == PLL_LAST) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end
        end
        S_WAIT_LOCK: begin
          // A lock arriving in the timeout cycle wins over the retry.
          if (lock_s_q) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end
`ifdef HDMI_PLL_RETRY_EN
          else if (cnt_q == TMO_LAST) begin
            state_q <= S_PLL_RST;
            cnt_q   <= '0;
            if (retry_q != 4'hF) retry_q <= retry_q + 4'd1;
          end
`endif
        end
        S_STABLE: begin
          // Lock loss wins over the terminal count.
          if (!lock_s_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= S_SER_REL;
            cnt_q   <= '0;
          end
        end
        S_SER_REL: begin
          if (!lock_s_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_PLL_RST;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pll_rst = state_q[0];
  assign ser_rst = ~(state_q[3] | state_q[4]);
  assign pix_rst = ~state_q[4];
  assign ready   = state_q[4];

`ifdef HDMI_PLL_RETRY_EN
  assign retry_count = retry_q;
`else
  assign retry_count = 4'd0;
`endif

endmodule

// File: tb/tb_hdmi_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// Testbench for hdmi_clk_rst_seq with LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32, PLL_RST_CYCLES=4, SER_TO_PIX_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// "e" below counts rising edges after reset release (release happens at e=0).
// ---------------------------------------------------------------------------
module tb_hdmi_clk_rst_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       lock;
  logic       pll_rst;
  logic       ser_rst;
  logic       pix_rst;
  logic       ready;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  hdmi_clk_rst_seq #(
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .PLL_RST_CYCLES     (4),
    .SER_TO_PIX_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lock       (lock),
    .pll_rst    (pll_rst),
    .ser_rst    (ser_rst),
    .pix_rst    (pix_rst),
    .ready      (ready),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lock;
    int   cycles;
    logic pll;
    logic ser;
    logic pix;
    logic rdy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 unit after a rising edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    int highs;
    int ser_fell;
    int last_e;

    // Release sequence, run, lock drop for 20 cycles, second release.
    // Lock rises after e=10: sync e11/e12, STABLE e13, SER_REL e21, RUN e25.
    // Lock drops after e=45: RUN ends at e48. Lock back after e=65:
    // STABLE e68, SER_REL e76, RUN e80.
    vecs[0]  = '{1'b0,  0, 1'b1, 1'b1, 1'b1, 1'b0};  // e0  reset values
    vecs[1]  = '{1'b0,  3, 1'b1, 1'b1, 1'b1, 1'b0};  // e3  pll pulse cycle 4
    vecs[2]  = '{1'b0,  1, 1'b0, 1'b1, 1'b1, 1'b0};  // e4  pll released
    vecs[3]  = '{1'b0,  6, 1'b0, 1'b1, 1'b1, 1'b0};  // e10 waiting
    vecs[4]  = '{1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0};  // e20 last STABLE cycle
    vecs[5]  = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0};  // e21 ser released (+11)
    vecs[6]  = '{1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b0};  // e24 gap
    vecs[7]  = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1};  // e25 RUN (+4)
    vecs[8]  = '{1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b1};  // e45 still RUN
    vecs[9]  = '{1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b1};  // e47 sync latency
    vecs[10] = '{1'b0,  1, 1'b0, 1'b1, 1'b1, 1'b0};  // e48 lock loss seen
    vecs[11] = '{1'b0, 17, 1'b0, 1'b1, 1'b1, 1'b0};  // e65 20 cycles low
    vecs[12] = '{1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0};  // e75
    vecs[13] = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0};  // e76 ser released
    vecs[14] = '{1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b0};  // e79
    vecs[15] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1};  // e80 RUN again

    do_reset();
    for (int i = 0; i < 16; i++) begin
      lock = vecs[i].lock;
      adv(vecs[i].cycles);
      check($sformatf("vec%0d pll_rst", i), int'(pll_rst), int'(vecs[i].pll));
      check($sformatf("vec%0d ser_rst", i), int'(ser_rst), int'(vecs[i].ser));
      check($sformatf("vec%0d pix_rst", i), int'(pix_rst), int'(vecs[i].pix));
      check($sformatf("vec%0d ready", i),   int'(ready),   int'(vecs[i].rdy));
      check($sformatf("vec%0d retry", i),   int'(retry_count), 0);
    end

    // Short lock during STABLE. WAIT_LOCK entered e4, lock high after e4..e9,
    // STABLE e7..e11, back to WAIT_LOCK at e12. A restarted timeout fires at
    // e44; one that kept counting from e4 would fire at e36.
    do_reset();
    adv(4);
    lock     = 1'b1;
    ser_fell = 0;
    for (int e = 5; e <= 44; e++) begin
      adv(1);
      if (e == 9) lock = 1'b0;
      if (!ser_rst) ser_fell++;
`ifdef HDMI_PLL_RETRY_EN
      check($sformatf("glitch e%0d pll_rst", e), int'(pll_rst), (e == 44) ? 1 : 0);
`else
      check($sformatf("glitch e%0d pll_rst", e), int'(pll_rst), 0);
`endif
    end
    check("glitch ser_rst low cycles", ser_fell, 0);
`ifdef HDMI_PLL_RETRY_EN
    check("glitch retry", int'(retry_count), 1);
`else
    check("glitch retry", int'(retry_count), 0);
`endif

    // Lock held low. With retry: 4-cycle pulse every 36 edges, retry_count
    // steps once per pulse and saturates. Without: a single 4-cycle pulse.
    do_reset();
    highs = int'(pll_rst);
`ifdef HDMI_PLL_RETRY_EN
    check("retry e0 pll_rst", int'(pll_rst), 1);
    last_e = 36 * 17 + 4;
    for (int e = 1; e <= last_e; e++) begin
      adv(1);
      check($sformatf("retry e%0d pll_rst", e), int'(pll_rst), ((e % 36) < 4) ? 1 : 0);
      check($sformatf("retry e%0d count", e), int'(retry_count), min15(e / 36));
    end
`else
    last_e = 200;
    for (int e = 1; e <= last_e; e++) begin
      adv(1);
      highs += int'(pll_rst);
      check($sformatf("noretry e%0d count", e), int'(retry_count), 0);
    end
    check("noretry pll_rst high cycles", highs, 4);
    check("noretry pll_rst final", int'(pll_rst), 0);
`endif

    // From WAIT_LOCK, bring lock up and stop in SER_REL (3 + 8 edges later),
    // then assert reset between clock edges.
    lock = 1'b1;
    adv(11);
    check("serrel ser_rst", int'(ser_rst), 0);
    check("serrel pix_rst", int'(pix_rst), 1);
    check("serrel ready", int'(ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async pll_rst", int'(pll_rst), 1);
    check("async ser_rst", int'(ser_rst), 1);
    check("async pix_rst", int'(pix_rst), 1);
    check("async ready", int'(ready), 0);
    check("async retry", int'(retry_count), 0);
    lock = 1'b0;
    adv(2);
    reset = 1'b0;
    adv(4);
    check("restart pll_rst low", int'(pll_rst), 0);
    check("restart retry", int'(retry_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
